uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//   Serial-to-parallel UART receiver: 8N1, LSB first, idle-high line, clock-per-bit timing.
//   It is the receive-side counterpart of UART_TX. It recovers bytes from the PC/loopback
//   serial line and presents them on a valid/ready output with a one-byte holding register.
//   It flags framing errors and overruns for the status LEDs and seven-segment logic.
// PARAMETERS
//   CLKS_PER_BIT  868  i_clk cycles per UART bit (100 MHz / 115200); legal range >= 4
//   DATA_BITS     8    payload bits per frame; fixed at 8
// PORTS
//   i_clk          in   1  system clock; all logic on rising edge
//   i_rst          in   1  synchronous, active-high reset
//   i_rx_serial    in   1  asynchronous serial line; idle = 1
//   i_rx_ready     in   1  consumer accepts o_rx_data when o_rx_dv & i_rx_ready
//   o_rx_data      out  8  received byte; stable while o_rx_dv = 1
//   o_rx_dv        out  1  holding register full; held until accepted
//   o_frame_err    out  1  one-cycle pulse: stop bit sampled 0
//   o_overrun      out  1  one-cycle pulse: byte completed while holding register full
//   o_rx_busy      out  1  1 in every state except IDLE
// BEHAVIOUR
//   Reset values: o_rx_data = 0, o_rx_dv = 0, o_frame_err = 0, o_overrun = 0, o_rx_busy = 0.
//     Synchronizer flops reset to 1. Bit counter and index reset to 0. State = IDLE.
//   Reset mid-frame aborts the frame with no dv, error or overrun pulse.
//   Input path: 2-flop synchronizer; the FSM sees only the synchronized bit rx_s.
//   Counter clk_cnt has width $clog2(CLKS_PER_BIT). bit_idx has 3 bits.
//   IDLE:      rx_s == 0 -> START, clk_cnt = 0. Otherwise stay.
//   START:     at clk_cnt == (CLKS_PER_BIT-1)/2 (mid start bit), sample rx_s.
//              rx_s == 0 -> DATA, clk_cnt = 0, bit_idx = 0.
//              rx_s == 1 -> IDLE (glitch rejected, no flags).
//   DATA:      at clk_cnt == CLKS_PER_BIT-1, shift_reg[bit_idx] <= rx_s and clk_cnt = 0.
//              bit_idx == 7 -> STOP. Otherwise bit_idx + 1.
//   STOP:      at clk_cnt == CLKS_PER_BIT-1, sample rx_s.
//              rx_s == 1 -> deliver shift_reg, then IDLE.
//              rx_s == 0 -> o_frame_err pulse, byte discarded, then BREAK.
//   BREAK:     wait for rx_s == 1, then IDLE. Covers break and stuck-low lines.
//   Return from STOP to IDLE is mid stop bit, so back-to-back frames are accepted.
//   Delivery (same cycle as the STOP sample):
//     o_rx_dv == 0, or o_rx_dv & i_rx_ready -> o_rx_data <= shift_reg, o_rx_dv <= 1.
//     Otherwise -> o_overrun pulse; new byte dropped; held byte and o_rx_dv unchanged.
//   Accept: o_rx_dv & i_rx_ready with no same-cycle delivery -> o_rx_dv <= 0 next cycle.
//     Simultaneous accept and delivery -> o_rx_dv stays 1 with the new data, no overrun.
//   i_rx_ready while o_rx_dv == 0 has no effect.
//   Latency: first i_clk edge seeing i_rx_serial = 0 to o_rx_dv rising is
//     2 + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles, +/-1.
//     The bench checks against a +/-2 cycle window.
//   o_frame_err and o_overrun never assert in the same cycle.
// TESTING (CLKS_PER_BIT = 16, UART_TX looped back to i_rx_serial, i_rx_ready = 1 unless stated)
//   1. Send 0x26
//      -> one o_rx_dv rise, o_rx_data = 0x26, within the latency window; no flags.
//   2. Drive i_rx_serial low for 5 cycles, then high
//      -> START rejects it; no o_rx_dv, no flags; FSM back in IDLE within 10 cycles.
//   3. Hand-driven frame 0xA5 with stop bit 0, then line high
//      -> one o_frame_err pulse; o_rx_dv stays 0.
//      -> Next frame 0x3C is received correctly.
//   4. i_rx_ready = 0; send 0x55 then 0xAA back-to-back
//      -> o_rx_data = 0x55, o_rx_dv = 1; one o_overrun pulse at the 0xAA stop sample.
//      -> Raise i_rx_ready for 1 cycle: o_rx_dv falls.
//   5. Assert i_rst for 1 cycle during DATA of 0x81
//      -> all outputs at reset values next cycle, no dv.
//      -> Following frame 0x7E is received correctly.
//   6. Send 0x00, 0xFF, 0x0F back-to-back with no idle gap
//      -> three o_rx_dv acceptances in that order; no frame_err or overrun.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART receiver for 8N1 frames, LSB first, on an idle-high line.
// A 2-flop synchronizer feeds a five-state FSM that times each bit with a cycle counter.
// Received bytes go into a one-byte holding register with a valid/ready handshake.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_dv,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Start bit is re-checked near its middle; every later bit is sampled one full bit period on.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   dv_q, dv_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and output holding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: bit timing, sampling, delivery into the holding register and flag pulses.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    dv_d        = dv_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a delivery in the STOP branch below overrides this.
    if (dv_q && i_rx_ready) begin
      dv_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Line went high again before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            // Leaving mid stop bit lets the next start edge be caught without a gap.
            state_d = S_IDLE;
            if (!dv_q || i_rx_ready) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  assign o_rx_data   = data_q;
  assign o_rx_dv     = dv_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer with CLKS_PER_BIT = 16.
// Stimulus bit-bangs frames and queues the bytes the receiver should hand out;
// a monitor pops and compares on every accepted byte and counts flag pulses.
module tb_uart_rx_framer;

  localparam int CPB     = 16;
  localparam int LAT_EXP = 2 + 1 + (CPB - 1) / 2 + 9 * CPB;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int         n_cmp;
  int         n_bad;
  int         cyc;
  int         start_cyc;
  int         lat_arm;
  int         err_seen, err_exp;
  int         ovr_seen, ovr_exp;
  logic [7:0] exp_q[$];

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_serial (rx_serial),
    .i_rx_ready  (rx_ready),
    .o_rx_data   (rx_data),
    .o_rx_dv     (rx_dv),
    .o_frame_err (frame_err),
    .o_overrun   (overrun),
    .o_rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 10-bit frame: start 0, eight data bits LSB first, then the given stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    start_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      repeat (CPB) tick();
    end
    rx_serial = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d byte(s) still expected after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_flags(input string name);
    chk({name, "_frame_err_count"}, 32'(err_seen), 32'(err_exp));
    chk({name, "_overrun_count"}, 32'(ovr_seen), 32'(ovr_exp));
  endtask

  // Monitor: samples on the falling edge, compares accepted bytes and counts pulses.
  initial begin
    logic       dv_prev;
    logic [7:0] e;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) err_seen++;
      if (overrun) ovr_seen++;
      if (frame_err || overrun) chk("flags_exclusive", 32'(frame_err & overrun), 32'd0);
      if (rx_dv && !dv_prev && lat_arm != 0) begin
        lat_arm = 0;
        n_cmp++;
        if ((cyc - start_cyc) < LAT_EXP - 2 || (cyc - start_cyc) > LAT_EXP + 2) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles, expected %0d +/-2", cyc - start_cyc, LAT_EXP);
        end
      end
      dv_prev = rx_dv;
      if (rx_dv && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_dv: got byte %02h, expected no byte (cycle %0d)", rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    n_cmp = 0; n_bad = 0;
    err_seen = 0; err_exp = 0; ovr_seen = 0; ovr_exp = 0;
    lat_arm = 0; start_cyc = 0;
    rst = 1'b1; rx_serial = 1'b1; rx_ready = 1'b1;
    repeat (3) tick();
    chk("reset_dv", 32'(rx_dv), 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single byte with latency check.
    lat_arm = 1;
    send_byte(8'h26);
    wait_drain(40, "t1_drain");
    chk("t1_latency_seen", 32'(lat_arm), 32'd0);
    check_flags("t1");

    // Short glitch on an idle line.
    rx_serial = 1'b0;
    repeat (5) tick();
    rx_serial = 1'b1;
    repeat (10) tick();
    chk("t2_busy_after_glitch", 32'(rx_busy), 32'd0);
    repeat (2 * CPB) tick();
    check_flags("t2");

    // Frame with a low stop bit, then a good frame.
    send_frame(8'hA5, 1'b0);
    err_exp++;
    repeat (2 * CPB) tick();
    chk("t3_dv_after_frame_err", 32'(rx_dv), 32'd0);
    check_flags("t3_err");
    send_byte(8'h3C);
    wait_drain(40, "t3_drain");
    check_flags("t3");

    // Holding register full: second byte is dropped with an overrun.
    rx_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    ovr_exp++;
    repeat (4) tick();
    chk("t4_dv_held", 32'(rx_dv), 32'd1);
    chk("t4_data_held", 32'(rx_data), 32'h55);
    check_flags("t4_ovr");
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("t4_dv_after_accept", 32'(rx_dv), 32'd0);
    wait_drain(4, "t4_drain");
    rx_ready = 1'b1;

    // Reset in the middle of the data bits.
    rx_serial = 1'b0;
    repeat (CPB) tick();
    rx_serial = 1'b1;
    repeat (CPB) tick();
    rx_serial = 1'b0;
    repeat (2 * CPB) tick();
    chk("t5_busy_before_reset", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    rx_serial = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_dv", 32'(rx_dv), 32'd0);
    chk("t5_rst_data", 32'(rx_data), 32'd0);
    chk("t5_rst_frame_err", 32'(frame_err), 32'd0);
    chk("t5_rst_overrun", 32'(overrun), 32'd0);
    chk("t5_rst_busy", 32'(rx_busy), 32'd0);
    repeat (12 * CPB) tick();
    send_byte(8'h7E);
    wait_drain(40, "t5_drain");
    check_flags("t5");

    // Back-to-back frames with no idle gap.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h0F);
    wait_drain(40, "t6_drain");
    check_flags("t6");

    // Random bytes with random idle gaps, some of them zero.
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
      repeat ($urandom_range(0, 2) * CPB + $urandom_range(0, 3)) tick();
    end
    wait_drain(400, "rand_drain");
    check_flags("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
